ethernet_mmio_responder: RTL and testbench

// - BedRock uncached I/O responder for the Ethernet device window: accepts processor io_cmd
//   (rd/wr), updates TX frame buffer and control regs, returns exactly one io_resp per cmd.
// - Responder end of the proc->eth io_cmd path; TX MAC reads the frame buffer via a side port.

---
 rtl/ethernet_mmio_responder_pkg.sv | 85 ++++++++
 rtl/ethernet_mmio_responder_txbuf.sv | 29 ++
 rtl/ethernet_mmio_responder.sv | 165 ++++++++++++++++
 tb/tb_ethernet_mmio_responder.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ethernet_mmio_responder_pkg.sv
// Shared definitions for the Ethernet MMIO window: BedRock encodings, register map
// offsets and the size/byte-lane helpers used by the responder and the MAC wrapper.
package ethernet_mmio_responder_pkg;

    typedef enum logic [3:0] {
        e_bedrock_mem_rd    = 4'd0,
        e_bedrock_mem_wr    = 4'd1,
        e_bedrock_mem_uc_rd = 4'd2,
        e_bedrock_mem_uc_wr = 4'd3
    } bedrock_mem_type_e;

    typedef enum logic [2:0] {
        e_bedrock_msg_size_1 = 3'd0,
        e_bedrock_msg_size_2 = 3'd1,
        e_bedrock_msg_size_4 = 3'd2,
        e_bedrock_msg_size_8 = 3'd3
    } bedrock_msg_size_e;

    typedef enum logic [1:0] {
        e_idle,
        e_exec,
        e_resp
    } state_e;

    typedef enum logic [2:0] {
        e_region_tx_buf,
        e_region_tx_len,
        e_region_tx_send,
        e_region_status,
        e_region_err_clr,
        e_region_none
    } region_e;

    localparam logic [12:0] tx_len_offset  = 13'h1000;
    localparam logic [12:0] tx_send_offset = 13'h1008;
    localparam logic [12:0] status_offset  = 13'h1010;
    localparam logic [12:0] err_clr_offset = 13'h1018;

    // Registers decode on their 8-byte word; TX_BUF owns 0x0000-0x07FF.
    function automatic region_e region_decode(input logic [12:0] offset);
        if (offset[12:11] == 2'b00)                     return e_region_tx_buf;
        else if (offset[12:3] == tx_len_offset[12:3])   return e_region_tx_len;
        else if (offset[12:3] == tx_send_offset[12:3])  return e_region_tx_send;
        else if (offset[12:3] == status_offset[12:3])   return e_region_status;
        else if (offset[12:3] == err_clr_offset[12:3])  return e_region_err_clr;
        else                                            return e_region_none;
    endfunction

    // Larger BedRock sizes are clamped to a full 64-bit word.
    function automatic logic [3:0] size_bytes(input logic [2:0] size);
        case (size)
            e_bedrock_msg_size_1: return 4'd1;
            e_bedrock_msg_size_2: return 4'd2;
            e_bedrock_msg_size_4: return 4'd4;
            default:              return 4'd8;
        endcase
    endfunction

    function automatic logic [2:0] byte_offset(input logic [2:0] size, input logic [2:0] addr_lo);
        logic [3:0] align;
        align = ~(size_bytes(size) - 4'd1);
        return addr_lo & align[2:0];
    endfunction

    function automatic logic [7:0] byte_mask(input logic [2:0] size, input logic [2:0] addr_lo);
        logic [7:0] base;
        case (size)
            e_bedrock_msg_size_1: base = 8'h01;
            e_bedrock_msg_size_2: base = 8'h03;
            e_bedrock_msg_size_4: base = 8'h0f;
            default:              base = 8'hff;
        endcase
        return base << byte_offset(size, addr_lo);
    endfunction

    function automatic logic [63:0] lane_mask(input logic [2:0] size);
        case (size)
            e_bedrock_msg_size_1: return 64'h0000_0000_0000_00ff;
            e_bedrock_msg_size_2: return 64'h0000_0000_0000_ffff;
            e_bedrock_msg_size_4: return 64'h0000_0000_ffff_ffff;
            default:              return 64'hffff_ffff_ffff_ffff;
        endcase
    endfunction

endpackage

// File: rtl/ethernet_mmio_responder_txbuf.sv
// One bank of the TX frame buffer: 64-bit words, byte-masked write, synchronous read
// that returns the pre-write contents when read and write hit the same word.
module ethernet_mmio_responder_txbuf #(
    parameter int  words_p      = 256,
    localparam int addr_width_lp = $clog2(words_p)
) (
    input  logic                     clk,
    input  logic                     w_v,
    input  logic [addr_width_lp-1:0] w_addr,
    input  logic [7:0]               w_mask,
    input  logic [63:0]              w_data,
    input  logic                     r_v,
    input  logic [addr_width_lp-1:0] r_addr,
    output logic [63:0]              r_data
);

    logic [63:0] mem [words_p];

    // NOTE: storage and read register carry no reset so this maps onto block RAM.
    always_ff @(posedge clk) begin
        if (w_v) begin
            for (int b = 0; b < 8; b++) begin
                if (w_mask[b]) mem[w_addr][8*b +: 8] <= w_data[8*b +: 8];
            end
        end
        if (r_v) r_data <= mem[r_addr];
    end

endmodule

// File: rtl/ethernet_mmio_responder.sv
// BedRock uncached I/O responder for the Ethernet window: one command in flight,
// TX frame buffer plus TX control/status registers, exactly one response per command.
module ethernet_mmio_responder
    import ethernet_mmio_responder_pkg::*;
#(
    parameter int  paddr_width_p        = 40,
    parameter int  lce_id_width_p       = 4,
    parameter int  tx_buf_words_p       = 256,
    localparam int tx_buf_addr_width_lp = $clog2(tx_buf_words_p)
) (
    input  logic                            clk_i,
    input  logic                            reset_n_i,
    input  logic                            io_cmd_v_i,
    output logic                            io_cmd_ready_and_o,
    input  logic [3:0]                      io_cmd_type_i,
    input  logic [paddr_width_p-1:0]        io_cmd_addr_i,
    input  logic [2:0]                      io_cmd_size_i,
    input  logic [lce_id_width_p-1:0]       io_cmd_lce_id_i,
    input  logic [63:0]                     io_cmd_data_i,
    output logic                            io_resp_v_o,
    input  logic                            io_resp_ready_and_i,
    output logic [3:0]                      io_resp_type_o,
    output logic [paddr_width_p-1:0]        io_resp_addr_o,
    output logic [2:0]                      io_resp_size_o,
    output logic [lce_id_width_p-1:0]       io_resp_lce_id_o,
    output logic [63:0]                     io_resp_data_o,
    input  logic [tx_buf_addr_width_lp-1:0] tx_buf_raddr_i,
    output logic [63:0]                     tx_buf_rdata_o,
    output logic [10:0]                     tx_len_o,
    output logic                            tx_send_o,
    input  logic                            tx_busy_i,
    input  logic                            rx_pending_i
);

    state_e state, state_nxt;

    logic [3:0]                cmd_type;
    logic [paddr_width_p-1:0]  cmd_addr;
    logic [2:0]                cmd_size;
    logic [lce_id_width_p-1:0] cmd_lce_id;
    logic [63:0]               cmd_data;

    logic [10:0] tx_len;
    logic        drop;
    logic [63:0] reg_word;
    logic [63:0] buf_rdata;
    logic [63:0] rd_word;
    logic        buf_rd_v, buf_wr_v, cmd_hs;
    logic        is_rd, is_wr;
    region_e     region;
    logic [5:0]  shift;
    logic [7:0]  wmask;
    logic [63:0] wdata;
    logic [10:0] len_mask;
    logic [tx_buf_addr_width_lp-1:0] buf_addr;

    assign cmd_hs   = io_cmd_v_i & io_cmd_ready_and_o;
    assign region   = region_decode(cmd_addr[12:0]);
    assign is_rd    = (cmd_type == e_bedrock_mem_uc_rd);
    assign is_wr    = (cmd_type == e_bedrock_mem_uc_wr);
    assign shift    = {byte_offset(cmd_size, cmd_addr[2:0]), 3'b000};
    assign wmask    = byte_mask(cmd_size, cmd_addr[2:0]);
    assign wdata    = cmd_data << shift;
    assign len_mask = {{3{wmask[1]}}, {8{wmask[0]}}};
    assign buf_addr = cmd_addr[3 +: tx_buf_addr_width_lp];

    // NOTE: all sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) state <= e_idle;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            e_idle:  if (io_cmd_v_i)          state_nxt = e_exec;
            e_exec:                           state_nxt = e_resp;
            e_resp:  if (io_resp_ready_and_i) state_nxt = e_idle;
            default:                          state_nxt = e_idle;
        endcase
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        io_cmd_ready_and_o = 1'b0;
        io_resp_v_o        = 1'b0;
        buf_rd_v           = 1'b0;
        buf_wr_v           = 1'b0;
        tx_send_o          = 1'b0;
        case (state)
            e_idle: io_cmd_ready_and_o = 1'b1;
            e_exec: begin
                buf_rd_v  = is_rd && (region == e_region_tx_buf);
                buf_wr_v  = is_wr && (region == e_region_tx_buf);
                tx_send_o = is_wr && (region == e_region_tx_send) && cmd_data[0] && !tx_busy_i;
            end
            e_resp: io_resp_v_o = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            tx_len <= '0;
            drop   <= 1'b0;
        end else if (state == e_exec && is_wr) begin
            case (region)
                e_region_tx_len:  tx_len <= (tx_len & ~len_mask) | (wdata[10:0] & len_mask);
                e_region_tx_send: if (cmd_data[0] && tx_busy_i) drop <= 1'b1;
                e_region_err_clr: if (cmd_data[0]) drop <= 1'b0;
                default: ;
            endcase
        end
    end

    // Header is captured only in IDLE and register reads only in EXEC, so RESP stays stable.
    always_ff @(posedge clk_i) begin
        if (cmd_hs) begin
            cmd_type   <= io_cmd_type_i;
            cmd_addr   <= io_cmd_addr_i;
            cmd_size   <= io_cmd_size_i;
            cmd_lce_id <= io_cmd_lce_id_i;
            cmd_data   <= io_cmd_data_i;
        end
        if (state == e_exec) begin
            case (region)
                e_region_tx_len: reg_word <= {53'b0, tx_len};
                e_region_status: reg_word <= {61'b0, drop, rx_pending_i, tx_busy_i};
                default:         reg_word <= '0;
            endcase
        end
    end

    // The MAC gets its own bank so its reads never contend with command reads.
    ethernet_mmio_responder_txbuf #(.words_p(tx_buf_words_p)) u_tx_buf_cmd (
        .clk    (clk_i),
        .w_v    (buf_wr_v),
        .w_addr (buf_addr),
        .w_mask (wmask),
        .w_data (wdata),
        .r_v    (buf_rd_v),
        .r_addr (buf_addr),
        .r_data (buf_rdata)
    );

    ethernet_mmio_responder_txbuf #(.words_p(tx_buf_words_p)) u_tx_buf_mac (
        .clk    (clk_i),
        .w_v    (buf_wr_v),
        .w_addr (buf_addr),
        .w_mask (wmask),
        .w_data (wdata),
        .r_v    (1'b1),
        .r_addr (tx_buf_raddr_i),
        .r_data (tx_buf_rdata_o)
    );

    assign rd_word          = (region == e_region_tx_buf) ? buf_rdata : reg_word;
    assign io_resp_data_o   = is_rd ? ((rd_word >> shift) & lane_mask(cmd_size)) : '0;
    assign io_resp_type_o   = cmd_type;
    assign io_resp_addr_o   = cmd_addr;
    assign io_resp_size_o   = cmd_size;
    assign io_resp_lce_id_o = cmd_lce_id;
    assign tx_len_o         = tx_len;

endmodule

// File: tb/tb_ethernet_mmio_responder.sv
// Scoreboard bench for ethernet_mmio_responder: expected responses are queued when a
// command is driven and compared when the responder hands its response over.
module tb_ethernet_mmio_responder;
    import ethernet_mmio_responder_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_v, cmd_ready;
    logic [3:0]  cmd_type;
    logic [39:0] cmd_addr;
    logic [2:0]  cmd_size;
    logic [3:0]  cmd_lce;
    logic [63:0] cmd_data;
    logic        resp_v, resp_ready;
    logic [3:0]  resp_type;
    logic [39:0] resp_addr;
    logic [2:0]  resp_size;
    logic [3:0]  resp_lce;
    logic [63:0] resp_data;
    logic [7:0]  tx_buf_raddr;
    logic [63:0] tx_buf_rdata;
    logic [10:0] tx_len;
    logic        tx_send, tx_busy, rx_pending;

    always #5 clk = ~clk;

    ethernet_mmio_responder dut (
        .clk_i               (clk),
        .reset_n_i           (reset_n),
        .io_cmd_v_i          (cmd_v),
        .io_cmd_ready_and_o  (cmd_ready),
        .io_cmd_type_i       (cmd_type),
        .io_cmd_addr_i       (cmd_addr),
        .io_cmd_size_i       (cmd_size),
        .io_cmd_lce_id_i     (cmd_lce),
        .io_cmd_data_i       (cmd_data),
        .io_resp_v_o         (resp_v),
        .io_resp_ready_and_i (resp_ready),
        .io_resp_type_o      (resp_type),
        .io_resp_addr_o      (resp_addr),
        .io_resp_size_o      (resp_size),
        .io_resp_lce_id_o    (resp_lce),
        .io_resp_data_o      (resp_data),
        .tx_buf_raddr_i      (tx_buf_raddr),
        .tx_buf_rdata_o      (tx_buf_rdata),
        .tx_len_o            (tx_len),
        .tx_send_o           (tx_send),
        .tx_busy_i           (tx_busy),
        .rx_pending_i        (rx_pending)
    );

    typedef struct {
        logic [3:0]  typ;
        logic [39:0] addr;
        logic [2:0]  size;
        logic [3:0]  lce;
        logic [63:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_cmp    = 0;
    int   n_err    = 0;
    int   send_cnt = 0;
    logic [3:0] lce_ctr = 4'd0;

    localparam logic [3:0] RD = e_bedrock_mem_uc_rd;
    localparam logic [3:0] WR = e_bedrock_mem_uc_wr;
    localparam logic [2:0] S1 = e_bedrock_msg_size_1;
    localparam logic [2:0] S2 = e_bedrock_msg_size_2;
    localparam logic [2:0] S4 = e_bedrock_msg_size_4;
    localparam logic [2:0] S8 = e_bedrock_msg_size_8;
    localparam logic [63:0] PATTERN  = 64'h1122_3344_5566_7788;
    localparam logic [63:0] PATCHED  = 64'h1122_3344_AB66_7788;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Response monitor: pops the scoreboard on every response handshake.
    exp_t mon_e;
    always @(negedge clk) begin
        if (tx_send) send_cnt++;
        if (reset_n && resp_v && resp_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_resp", 64'd1, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                check("resp_data", resp_data, mon_e.data);
                check("resp_addr", 64'(resp_addr), 64'(mon_e.addr));
                check("resp_lce_id", 64'(resp_lce), 64'(mon_e.lce));
                check("resp_type", 64'(resp_type), 64'(mon_e.typ));
                check("resp_size", 64'(resp_size), 64'(mon_e.size));
            end
        end
    end

    task automatic drive_cmd(input logic [3:0] typ, input logic [39:0] addr, input logic [2:0] size,
                             input logic [63:0] wdata, input logic [63:0] exp_data, input bit expect_resp);
        exp_t e;
        lce_ctr++;
        e = '{typ: typ, addr: addr, size: size, lce: lce_ctr, data: exp_data};
        if (expect_resp) sb.push_back(e);
        cmd_v    = 1'b1;
        cmd_type = typ;
        cmd_addr = addr;
        cmd_size = size;
        cmd_lce  = lce_ctr;
        cmd_data = wdata;
    endtask

    task automatic wait_accept();
        int n = 0;
        while (!cmd_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("cmd_accept", 64'(cmd_ready), 64'd1);
        @(posedge clk);
        #1 cmd_v = 1'b0;
    endtask

    task automatic wait_resp_v(output int lat);
        lat = 0;
        while (!resp_v && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("resp_drain", 64'(sb.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] typ, input logic [39:0] addr, input logic [2:0] size,
                         input logic [63:0] wdata, input logic [63:0] exp_data);
        int lat;
        @(negedge clk);
        drive_cmd(typ, addr, size, wdata, exp_data, 1'b1);
        wait_accept();
        wait_resp_v(lat);
        check("resp_latency", 64'(lat), 64'd2);
        drain();
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat, base;
        bit stable;
        logic [63:0] held;

        reset_n = 1'b0; cmd_v = 1'b0; cmd_type = '0; cmd_addr = '0; cmd_size = '0;
        cmd_lce = '0; cmd_data = '0; resp_ready = 1'b1; tx_buf_raddr = '0;
        tx_busy = 1'b0; rx_pending = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", 64'(cmd_ready), 64'd1);
        check("rst_resp_v", 64'(resp_v), 64'd0);
        check("rst_tx_len", 64'(tx_len), 64'd0);
        check("rst_tx_send", 64'(tx_send), 64'd0);
        reset_n = 1'b1;

        // TX buffer full-word and sub-word access, including a misaligned 2B read
        issue(WR, 40'h10, S8, PATTERN, 64'd0);
        issue(RD, 40'h10, S8, 64'd0, PATTERN);
        issue(WR, 40'h13, S1, 64'hAB, 64'd0);
        issue(RD, 40'h10, S8, 64'd0, PATCHED);
        issue(RD, 40'h12, S2, 64'd0, 64'hAB66);
        issue(RD, 40'h13, S2, 64'd0, 64'hAB66);
        issue(RD, 40'h14, S4, 64'd0, 64'h1122_3344);
        issue(RD, 40'h11, S1, 64'd0, 64'h77);

        tx_buf_raddr = 8'd2;
        @(negedge clk);
        @(negedge clk);
        check("mac_rdata", tx_buf_rdata, PATCHED);

        // TX_LEN / TX_SEND / STATUS / ERR_CLR
        issue(WR, 40'h1000, S8, 64'd64, 64'd0);
        check("tx_len_64", 64'(tx_len), 64'd64);
        base = send_cnt;
        issue(WR, 40'h1008, S8, 64'd1, 64'd0);
        check("tx_send_one_pulse", 64'(send_cnt - base), 64'd1);
        issue(WR, 40'h1008, S8, 64'd2, 64'd0);
        check("tx_send_bit0_clear", 64'(send_cnt - base), 64'd1);
        tx_busy = 1'b1;
        issue(WR, 40'h1008, S8, 64'd1, 64'd0);
        check("tx_send_busy_no_pulse", 64'(send_cnt - base), 64'd1);
        tx_busy = 1'b0;
        issue(RD, 40'h1010, S8, 64'd0, 64'h4);
        issue(WR, 40'h1018, S8, 64'd1, 64'd0);
        issue(RD, 40'h1010, S8, 64'd0, 64'h0);
        rx_pending = 1'b1;
        issue(RD, 40'h1010, S8, 64'd0, 64'h2);
        rx_pending = 1'b0;
        issue(RD, 40'h1000, S2, 64'd0, 64'd64);

        // Response back-pressure: response must hold and a second command must wait
        @(negedge clk);
        resp_ready = 1'b0;
        drive_cmd(RD, 40'h10, S8, 64'd0, PATCHED, 1'b1);
        wait_accept();
        wait_resp_v(lat);
        check("bp_latency", 64'(lat), 64'd2);
        held = resp_data;
        drive_cmd(WR, 40'h1000, S8, 64'd100, 64'd0, 1'b1);
        stable = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (!resp_v || resp_data !== held || cmd_ready) stable = 1'b0;
        end
        check("bp_hold", 64'(stable), 64'd1);
        check("bp_held_data", held, PATCHED);
        check("bp_tx_len_unchanged", 64'(tx_len), 64'd64);
        @(posedge clk);
        #1 resp_ready = 1'b1;
        wait_accept();
        drain();
        check("bp_second_cmd", 64'(tx_len), 64'd100);

        // Unmapped and unsupported accesses still respond and change nothing
        issue(RD, 40'h1800, S8, 64'd0, 64'd0);
        issue(WR, 40'h1800, S8, 64'hFFFF, 64'd0);
        check("unmapped_wr_tx_len", 64'(tx_len), 64'd100);
        issue(RD, 40'h1010, S8, 64'd0, 64'd0);
        issue(4'(e_bedrock_mem_wr), 40'h10, S8, 64'd0, 64'd0);
        issue(4'(e_bedrock_mem_rd), 40'h10, S8, 64'd0, 64'd0);
        issue(RD, 40'h10, S8, 64'd0, PATCHED);

        // Reset while a response is pending
        tx_busy = 1'b1;
        issue(WR, 40'h1008, S8, 64'd1, 64'd0);
        tx_busy = 1'b0;
        issue(RD, 40'h1010, S8, 64'd0, 64'h4);
        @(negedge clk);
        resp_ready = 1'b0;
        drive_cmd(RD, 40'h10, S8, 64'd0, PATCHED, 1'b0);
        wait_accept();
        wait_resp_v(lat);
        check("pre_reset_resp_v", 64'(resp_v), 64'd1);
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_resp_v", 64'(resp_v), 64'd0);
        check("midrst_ready", 64'(cmd_ready), 64'd1);
        check("midrst_tx_len", 64'(tx_len), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        resp_ready = 1'b1;
        sb.delete();
        issue(RD, 40'h1010, S8, 64'd0, 64'h0);
        issue(RD, 40'h10, S8, 64'd0, PATCHED);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
